incline_avg: RTL and testbench

//  Consumes the vld/incline stream from the inertial interface and produces a

---
 rtl/incline_avg_if.sv | 21 ++
 rtl/incline_avg.sv | 115 +++++++++++
 tb/tb_incline_avg.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/incline_avg_if.sv
// Sample/result bundle between the inertial interface and the incline filter.
interface incline_avg_if #(
    parameter int SAT_W = 10
);
    logic                    clr;
    logic                    vld;
    logic signed [12:0]      incline;
    logic signed [SAT_W-1:0] incline_avg;
    logic                    avg_vld;
    logic                    filled;

    modport master (
        output clr, vld, incline,
        input  incline_avg, avg_vld, filled
    );

    modport slave (
        input  clr, vld, incline,
        output incline_avg, avg_vld, filled
    );
endinterface

// File: rtl/incline_avg.sv
// Running-sum moving average of the incline stream over 2**LOG2_DEPTH samples,
// saturated to a SAT_W-bit signed result. Output is withheld until the window
// has been filled once after reset or clear.
module incline_avg #(
    parameter int LOG2_DEPTH = 3,
    parameter int SAT_W      = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    incline_avg_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = 13 + LOG2_DEPTH;

    localparam logic       FILL = 1'b0;
    localparam logic       RUN  = 1'b1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (SAT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [12:0]       buf_mem [DEPTH];
    logic [LOG2_DEPTH-1:0]    wr_ptr;
    logic [LOG2_DEPTH-1:0]    cnt;
    logic                     state;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  avg;
    logic signed [SAT_W-1:0]  sat_val;
    logic                     emit_pending;
    logic                     accept;
    logic signed [SAT_W-1:0]  incline_avg_reg;
    logic                     avg_vld_reg;
    logic                     filled_reg;

    // A clear in the same cycle discards the sample.
    assign accept = bus.vld & ~bus.clr;

    assign bus.incline_avg = incline_avg_reg;
    assign bus.avg_vld     = avg_vld_reg;
    assign bus.filled      = filled_reg;

    // New sum: add the incoming sample, drop the one it overwrites (zero while filling).
    always_comb begin
        sum_next = sum + SUM_W'(bus.incline) - SUM_W'(buf_mem[wr_ptr]);
    end

    // Average of the registered sum, clamped into the output range.
    always_comb begin
        avg = sum >>> LOG2_DEPTH;
        if (avg > SAT_MAX) begin
            sat_val = SAT_MAX[SAT_W-1:0];
        end else if (avg < SAT_MIN) begin
            sat_val = SAT_MIN[SAT_W-1:0];
        end else begin
            sat_val = avg[SAT_W-1:0];
        end
    end

    // Circular sample history; cleared entries read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (accept) begin
            buf_mem[wr_ptr] <= bus.incline;
        end
    end

    // Sum/pointer/FILL-RUN control; the output registers one cycle after the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum             <= '0;
            wr_ptr          <= '0;
            cnt             <= '0;
            state           <= FILL;
            filled_reg      <= 1'b0;
            emit_pending    <= 1'b0;
            avg_vld_reg     <= 1'b0;
            incline_avg_reg <= '0;
        end else if (bus.clr) begin
            sum          <= '0;
            wr_ptr       <= '0;
            cnt          <= '0;
            state        <= FILL;
            filled_reg   <= 1'b0;
            emit_pending <= 1'b0;
            avg_vld_reg  <= 1'b0;
        end else begin
            avg_vld_reg  <= emit_pending;
            if (emit_pending) begin
                incline_avg_reg <= sat_val;
            end
            emit_pending <= 1'b0;
            if (accept) begin
                sum    <= sum_next;
                wr_ptr <= wr_ptr + 1'b1;
                if (state == FILL) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LOG2_DEPTH'(DEPTH - 1)) begin
                        state        <= RUN;
                        filled_reg   <= 1'b1;
                        emit_pending <= 1'b1;
                    end
                end else begin
                    emit_pending <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_incline_avg.sv
// Scoreboard bench for incline_avg: stimulus pushes expected averages computed
// from a queue of recent samples; a negedge monitor pops and compares them.
module tb_incline_avg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    incline_avg_if #(.SAT_W(10)) bus ();

    incline_avg #(.LOG2_DEPTH(3), .SAT_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_seen   = 0;

    // Reference state
    int win[$];
    int mcnt = 0;
    bit mfilled = 1'b0;
    int exp_q[$];
    bit prev_emitted = 1'b0;
    int hold_val = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Mean of the last 8 samples (missing ones count as zero), floored and clamped.
    function automatic int model_avg();
        int s = 0;
        int a;
        foreach (win[i]) s += win[i];
        if (s >= 0) a = s / 8;
        else        a = -((-s + 7) / 8);
        if (a > 511)  a = 511;
        if (a < -512) a = -512;
        return a;
    endfunction

    function automatic void model_clear();
        win.delete();
        mcnt = 0;
        mfilled = 1'b0;
        prev_emitted = 1'b0;
    endfunction

    // One clock cycle of stimulus; model advances with the edge this drive targets.
    task automatic step(bit v, bit c, int x);
        bus.vld     = v;
        bus.clr     = c;
        bus.incline = 13'(x);
        if (c) begin
            if (prev_emitted) void'(exp_q.pop_back());
            model_clear();
        end else if (v) begin
            win.push_back(x);
            if (win.size() > 8) void'(win.pop_front());
            mcnt++;
            if (mcnt >= 8) mfilled = 1'b1;
            if (mfilled) begin
                exp_q.push_back(model_avg());
                prev_emitted = 1'b1;
            end else begin
                prev_emitted = 1'b0;
            end
        end else begin
            prev_emitted = 1'b0;
        end
        @(posedge clk);
        #1;
        check("filled", int'(bus.filled), int'(mfilled));
        bus.vld = 1'b0;
        bus.clr = 1'b0;
    endtask

    task automatic repeat_step(int n, int x);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, x);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.vld = 1'b0;
        bus.clr = 1'b0;
        exp_q.delete();
        model_clear();
        hold_val = 0;
        @(posedge clk);
        #1;
        check("rst_avg", int'(bus.incline_avg), 0);
        check("rst_avg_vld", int'(bus.avg_vld), 0);
        check("rst_filled", int'(bus.filled), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every avg_vld must match the oldest expected value; otherwise the output holds.
    always @(negedge clk) begin
        if (bus.avg_vld) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_avg_vld: got value %0d with no expected entry at %0t",
                         bus.incline_avg, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("avg_value", int'(bus.incline_avg), e);
                hold_val = e;
            end
        end else begin
            check("avg_hold", int'(bus.incline_avg), hold_val);
        end
    end

    initial begin
        int seen0;
        bus.vld     = 1'b0;
        bus.clr     = 1'b0;
        bus.incline = '0;
        do_reset();

        // 1: fill with 100
        repeat_step(8, 100);
        step(1'b0, 1'b0, 0);
        check("t1_avg", int'(bus.incline_avg), 100);
        check("t1_filled", int'(bus.filled), 1);

        // 2: zeros then ramp of 80s
        step(1'b1, 1'b1, 0);
        repeat_step(8, 0);
        repeat_step(4, 80);
        step(1'b0, 1'b0, 0);
        check("t2_avg", int'(bus.incline_avg), 40);

        // 3: saturation both ways
        repeat_step(8, 4000);
        step(1'b0, 1'b0, 0);
        check("t3_pos_sat", int'(bus.incline_avg), 511);
        repeat_step(8, -4000);
        step(1'b0, 1'b0, 0);
        check("t3_neg_sat", int'(bus.incline_avg), -512);

        // 4: floor toward -inf, then max positive input
        step(1'b1, 1'b1, 0);
        repeat_step(7, 0);
        step(1'b1, 1'b0, -1);
        step(1'b0, 1'b0, 0);
        check("t4_floor", int'(bus.incline_avg), -1);
        repeat_step(8, 4095);
        step(1'b0, 1'b0, 0);
        check("t4_max", int'(bus.incline_avg), 511);

        // 5: clr beats vld in RUN
        step(1'b1, 1'b1, 77);
        check("t5_filled_clr", int'(bus.filled), 0);
        step(1'b0, 1'b0, 0);
        check("t5_no_avg_vld", int'(bus.avg_vld), 0);
        check("t5_hold", int'(bus.incline_avg), 511);
        repeat_step(8, 5);
        step(1'b0, 1'b0, 0);
        check("t5_avg", int'(bus.incline_avg), 5);

        // 6: reset mid-fill, refill, back-to-back outputs
        step(1'b1, 1'b1, 0);
        repeat_step(5, 300);
        do_reset();
        repeat_step(8, 20);
        step(1'b0, 1'b0, 0);
        check("t6_avg", int'(bus.incline_avg), 20);
        seen0 = n_seen;
        repeat_step(4, 20);
        step(1'b0, 1'b0, 0);
        check("t6_b2b_count", n_seen - seen0, 4);

        // Randomised traffic with occasional clr and reset
        for (int i = 0; i < 600; i++) begin
            int r;
            int x;
            r = int'($urandom_range(0, 199));
            if (r < 10) x = (r < 5) ? 4095 : -4096;
            else        x = int'($urandom_range(0, 8191)) - 4096;
            if (r == 199) do_reset();
            else step(r < 150, r >= 190, x);
        end

        repeat (3) step(1'b0, 1'b0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
